// File: rtl/fft_radix2_iter_if.sv
// Stream and status bundle for the iterative radix-2 FFT engine.
// The master side (source/sink of samples) drives start, the input samples
// and dout_ready; the slave side (the engine) drives the rest.
interface fft_radix2_iter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         start;
  logic                         inverse;
  logic signed [DATA_WIDTH-1:0] din_real;
  logic signed [DATA_WIDTH-1:0] din_imag;
  logic                         din_valid;
  logic                         din_ready;
  logic signed [DATA_WIDTH-1:0] dout_real;
  logic signed [DATA_WIDTH-1:0] dout_imag;
  logic                         dout_valid;
  logic                         dout_ready;
  logic                         busy;
  logic                         done;

  modport master (
    output start, inverse, din_real, din_imag, din_valid, dout_ready,
    input  din_ready, dout_real, dout_imag, dout_valid, busy, done
  );

  modport slave (
    input  start, inverse, din_real, din_imag, din_valid, dout_ready,
    output din_ready, dout_real, dout_imag, dout_valid, busy, done
  );
endinterface

// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT/IFFT. Samples are loaded in bit-reversed
// order, LOG2N stages of one butterfly per cycle run as a single-cycle
// read-modify-write on a register buffer (so no hazard between consecutive
// butterflies), each stage scales by 1/2, and bins stream out in natural order.
// The interface instance must be built with the same DATA_WIDTH as this module.
module fft_radix2_iter #(
  parameter int N          = 8,
  parameter int LOG2N      = 3,
  parameter int DATA_WIDTH = 16,
  parameter int TWID_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  fft_radix2_iter_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam int TW = TWID_WIDTH;
  localparam int PW = DW + TW + 1;  // full complex-product width
  localparam int SW = DW + 2;       // butterfly sum width
  localparam int KW = LOG2N - 1;    // twiddle index width (N >= 4)

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] OUTPUT  = 2'd3;

  localparam logic [LOG2N:0]   CNT_ONE    = {{LOG2N{1'b0}}, 1'b1};
  localparam logic [LOG2N:0]   CNT_LAST   = (LOG2N+1)'(N - 1);
  localparam logic [LOG2N:0]   CNT_END    = (LOG2N+1)'(N);
  localparam logic [LOG2N-1:0] IDX_ONE    = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [KW-1:0]    BFLY_ONE   = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0]    BFLY_LAST  = {KW{1'b1}};
  localparam logic signed [PW-1:0] RND    = {{(PW-1){1'b0}}, 1'b1} << (TW - 2);

  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = (2.0 ** (TW - 1)) - 1.0;

  // Twiddle ROM: cosine and sine of 2*pi*k/N, rounded half away from zero.
  logic signed [TW-1:0] rom_c_s [N/2];
  logic signed [TW-1:0] rom_s_s [N/2];
  for (genvar i = 0; i < N/2; i++) begin : g_rom
    localparam real CR = $cos(2.0 * PI * i / N) * AMP;
    localparam real SR = $sin(2.0 * PI * i / N) * AMP;
    localparam int  CI = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
    localparam int  SI = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
    assign rom_c_s[i] = TW'(CI);
    assign rom_s_s[i] = TW'(SI);
  end

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = {LOG2N{1'b0}};
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  logic [1:0]           state_r;
  logic [LOG2N:0]       cnt_r;
  logic [LOG2N-1:0]     stage_r;
  logic [KW-1:0]        bfly_r;
  logic                 inverse_r, din_ready_r, dout_valid_r, busy_r, done_r;
  logic signed [DW-1:0] dout_re_r, dout_im_r;
  logic signed [DW-1:0] buf_re_r [N];
  logic signed [DW-1:0] buf_im_r [N];

  logic [LOG2N-1:0]     j_s, h_s, m_s, g_s, a_s, b_s, ksh_s, kf_s;
  logic [KW-1:0]        k_s;
  logic signed [DW-1:0] a_re_s, a_im_s, b_re_s, b_im_s;
  logic signed [TW-1:0] wr_s, wi_s;
  logic signed [PW-1:0] t_re_f_s, t_im_f_s;
  logic signed [SW-1:0] t_re_s, t_im_s, sa_re_s, sa_im_s, sb_re_s, sb_im_s;
  logic signed [DW-1:0] na_re_s, na_im_s, nb_re_s, nb_im_s;

  // Butterfly addressing and arithmetic for the current (stage, butterfly).
  always_comb begin
    j_s   = {1'b0, bfly_r};
    h_s   = IDX_ONE << stage_r;
    m_s   = j_s & (h_s - IDX_ONE);
    g_s   = j_s >> stage_r;
    a_s   = ((g_s << stage_r) << 1'b1) + m_s;
    b_s   = a_s + h_s;
    ksh_s = LAST_STAGE - stage_r;
    kf_s  = m_s << ksh_s;
    k_s   = kf_s[KW-1:0];

    a_re_s = buf_re_r[a_s];
    a_im_s = buf_im_r[a_s];
    b_re_s = buf_re_r[b_s];
    b_im_s = buf_im_r[b_s];
    wr_s   = rom_c_s[k_s];
    if (inverse_r) begin
      wi_s = rom_s_s[k_s];
    end else begin
      wi_s = -rom_s_s[k_s];
    end

    t_re_f_s = PW'(b_re_s) * PW'(wr_s) - PW'(b_im_s) * PW'(wi_s);
    t_im_f_s = PW'(b_re_s) * PW'(wi_s) + PW'(b_im_s) * PW'(wr_s);
    t_re_s   = SW'((t_re_f_s + RND) >>> (TW - 1));
    t_im_s   = SW'((t_im_f_s + RND) >>> (TW - 1));
    sa_re_s  = SW'(a_re_s) + t_re_s;
    sa_im_s  = SW'(a_im_s) + t_im_s;
    sb_re_s  = SW'(a_re_s) - t_re_s;
    sb_im_s  = SW'(a_im_s) - t_im_s;
    na_re_s  = DW'(sa_re_s >>> 1);
    na_im_s  = DW'(sa_im_s >>> 1);
    nb_re_s  = DW'(sb_re_s >>> 1);
    nb_im_s  = DW'(sb_im_s >>> 1);
  end

  // Frame sequencing: load, compute, stream out; registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {(LOG2N+1){1'b0}};
      stage_r      <= {LOG2N{1'b0}};
      bfly_r       <= {KW{1'b0}};
      inverse_r    <= 1'b0;
      din_ready_r  <= 1'b0;
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      dout_re_r    <= {DW{1'b0}};
      dout_im_r    <= {DW{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r     <= LOAD;
            inverse_r   <= bus.inverse;
            busy_r      <= 1'b1;
            din_ready_r <= 1'b1;
            cnt_r       <= {(LOG2N+1){1'b0}};
          end
        end
        LOAD: begin
          if (bus.din_valid) begin
            if (cnt_r == CNT_LAST) begin
              state_r     <= COMPUTE;
              din_ready_r <= 1'b0;
              cnt_r       <= {(LOG2N+1){1'b0}};
              stage_r     <= {LOG2N{1'b0}};
              bfly_r      <= {KW{1'b0}};
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        COMPUTE: begin
          if (bfly_r == BFLY_LAST) begin
            bfly_r <= {KW{1'b0}};
            if (stage_r == LAST_STAGE) begin
              state_r      <= OUTPUT;
              cnt_r        <= {(LOG2N+1){1'b0}};
              dout_valid_r <= 1'b0;
            end else begin
              stage_r <= stage_r + IDX_ONE;
            end
          end else begin
            bfly_r <= bfly_r + BFLY_ONE;
          end
        end
        OUTPUT: begin
          // First cycle primes the output register; afterwards advance on accept.
          if (!dout_valid_r) begin
            dout_re_r    <= buf_re_r[cnt_r[LOG2N-1:0]];
            dout_im_r    <= buf_im_r[cnt_r[LOG2N-1:0]];
            dout_valid_r <= 1'b1;
            cnt_r        <= cnt_r + CNT_ONE;
          end else if (bus.dout_ready) begin
            if (cnt_r == CNT_END) begin
              dout_valid_r <= 1'b0;
              done_r       <= 1'b1;
              busy_r       <= 1'b0;
              state_r      <= IDLE;
              cnt_r        <= {(LOG2N+1){1'b0}};
            end else begin
              dout_re_r <= buf_re_r[cnt_r[LOG2N-1:0]];
              dout_im_r <= buf_im_r[cnt_r[LOG2N-1:0]];
              cnt_r     <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Sample buffer: bit-reversed writes during LOAD, in-place butterflies in COMPUTE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state_r)
        LOAD: begin
          if (bus.din_valid) begin
            buf_re_r[bitrev(cnt_r[LOG2N-1:0])] <= bus.din_real;
            buf_im_r[bitrev(cnt_r[LOG2N-1:0])] <= bus.din_imag;
          end
        end
        COMPUTE: begin
          buf_re_r[a_s] <= na_re_s;
          buf_im_r[a_s] <= na_im_s;
          buf_re_r[b_s] <= nb_re_s;
          buf_im_r[b_s] <= nb_im_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.din_ready  = din_ready_r;
  assign bus.dout_real  = dout_re_r;
  assign bus.dout_imag  = dout_im_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
endmodule

// File: tb/tb_fft_radix2_iter.sv
// Self-checking bench for fft_radix2_iter: directed and random frames are
// compared with a direct scaled DFT computed in real arithmetic.
module tb_fft_radix2_iter;
  localparam int N = 8, LOG2N = 3, DW = 16;
  localparam int N2 = 16, LOG2N2 = 4, DW2 = 12;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  fft_radix2_iter_if #(.DATA_WIDTH(DW))  bus  ();
  fft_radix2_iter_if #(.DATA_WIDTH(DW2)) bus2 ();

  fft_radix2_iter #(.N(N), .LOG2N(LOG2N), .DATA_WIDTH(DW), .TWID_WIDTH(16))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  fft_radix2_iter #(.N(N2), .LOG2N(LOG2N2), .DATA_WIDTH(DW2), .TWID_WIDTH(16))
    dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));

  int checks = 0, failures = 0;
  int x_re [N], x_im [N], got_re [N], got_im [N], exp_re [N], exp_im [N];
  int ref_re [N], ref_im [N];
  int comp_cycles, out_span;

  task automatic check_val(input string tag, input int obs, input int expv, input int tol);
    checks++;
    if (obs > expv + tol || obs < expv - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, expv, tol);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(0.5 - r);
  endfunction

  // Scaled DFT: X[k] = (1/N) * sum x[n] * exp(-/+ j*2*pi*n*k/N)
  task automatic model(input bit inv);
    for (int k = 0; k < N; k++) begin
      real sr, si, th, s;
      sr = 0.0; si = 0.0;
      s = inv ? 1.0 : -1.0;
      for (int n = 0; n < N; n++) begin
        th = 2.0 * PI * n * k / N;
        sr += x_re[n] * $cos(th) - s * x_im[n] * $sin(th);
        si += x_im[n] * $cos(th) + s * x_re[n] * $sin(th);
      end
      exp_re[k] = rnd(sr / N);
      exp_im[k] = rnd(si / N);
    end
  endtask

  task automatic cmp_model(input string tag, input int tol);
    for (int k = 0; k < N; k++) begin
      check_val($sformatf("%s_re[%0d]", tag, k), got_re[k], exp_re[k], tol);
      check_val($sformatf("%s_im[%0d]", tag, k), got_im[k], exp_im[k], tol);
    end
  endtask

  // rmode: 0 ready always, 1 ready every other cycle, 2 random ready
  task automatic run_frame(input bit inv, input int vprob, input int rmode,
                           input bit noise, input int abort_after);
    int in_i, out_i, cyc, last_acc, first_v, first_out, last_out;
    bit fin, v_pre, r_pre, ov_pre, or_pre;
    int od_re, od_im;
    in_i = 0; out_i = 0; cyc = 0; last_acc = -1; first_v = -1;
    first_out = 0; last_out = 0; fin = 1'b0;
    for (int k = 0; k < N; k++) begin got_re[k] = 99999; got_im[k] = 99999; end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.inverse = inv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("busy_after_start", int'(bus.busy), 1, 0);
    while (!fin && cyc < 3000) begin
      bus.din_valid = (in_i < N) && ($urandom_range(99) < vprob);
      bus.din_real  = DW'(x_re[(in_i < N) ? in_i : 0]);
      bus.din_imag  = DW'(x_im[(in_i < N) ? in_i : 0]);
      case (rmode)
        0:       bus.dout_ready = 1'b1;
        1:       bus.dout_ready = (cyc % 2) == 1;
        default: bus.dout_ready = $urandom_range(1) == 1;
      endcase
      if (noise) begin
        bus.start   = $urandom_range(1) == 1;
        bus.inverse = $urandom_range(1) == 1;
      end
      v_pre = bus.din_valid; r_pre = bus.din_ready;
      ov_pre = bus.dout_valid; or_pre = bus.dout_ready;
      od_re = bus.dout_real; od_im = bus.dout_imag;
      @(posedge clk); #1;
      cyc++;
      if (v_pre && r_pre) begin
        in_i++;
        if (in_i == N) last_acc = cyc;
      end
      if (ov_pre && or_pre) begin
        if (out_i < N) begin got_re[out_i] = od_re; got_im[out_i] = od_im; end
        if (out_i == 0) first_out = cyc;
        last_out = cyc;
        out_i++;
      end else if (ov_pre) begin
        check_val("hold_valid", int'(bus.dout_valid), 1, 0);
        check_val("hold_re", int'(bus.dout_real), od_re, 0);
        check_val("hold_im", int'(bus.dout_imag), od_im, 0);
      end
      if (bus.dout_valid && first_v < 0) first_v = cyc;
      if (abort_after > 0 && last_acc >= 0 && cyc == last_acc + abort_after) begin
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_busy", int'(bus.busy), 0, 0);
        check_val("rst_din_ready", int'(bus.din_ready), 0, 0);
        check_val("rst_dout_valid", int'(bus.dout_valid), 0, 0);
        check_val("rst_done", int'(bus.done), 0, 0);
        check_val("rst_dout_re", int'(bus.dout_real), 0, 0);
        check_val("rst_dout_im", int'(bus.dout_imag), 0, 0);
        fin = 1'b1;
      end else if (bus.done) begin
        check_val("bins_before_done", out_i, N, 0);
        fin = 1'b1;
      end
    end
    bus.start = 1'b0; bus.din_valid = 1'b0;
    if (!fin) check_val("frame_timeout", 0, 1, 0);
    if (abort_after == 0 && fin) begin
      @(posedge clk); #1;
      check_val("done_one_cycle", int'(bus.done), 0, 0);
      check_val("idle_not_busy", int'(bus.busy), 0, 0);
    end
    comp_cycles = first_v - last_acc - 1;
    out_span = last_out - first_out;
  endtask

  task automatic set_all(input int re);
    for (int n = 0; n < N; n++) begin x_re[n] = re; x_im[n] = 0; end
  endtask

  initial begin
    int in2, out2, cyc2, acc2, fv2;
    bit fin2, ov_pre2;
    int od2;
    bus.start = 1'b0; bus.inverse = 1'b0; bus.din_valid = 1'b0;
    bus.din_real = '0; bus.din_imag = '0; bus.dout_ready = 1'b0;
    bus2.start = 1'b0; bus2.inverse = 1'b0; bus2.din_valid = 1'b0;
    bus2.din_real = '0; bus2.din_imag = '0; bus2.dout_ready = 1'b0;
    rst = 1'b1; rst2 = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; rst2 = 1'b0;
    check_val("reset_busy", int'(bus.busy), 0, 0);
    check_val("reset_din_ready", int'(bus.din_ready), 0, 0);
    check_val("reset_dout_valid", int'(bus.dout_valid), 0, 0);
    check_val("reset_done", int'(bus.done), 0, 0);
    check_val("reset_dout_re", int'(bus.dout_real), 0, 0);
    check_val("reset_dout_im", int'(bus.dout_imag), 0, 0);
    // din_valid in IDLE is ignored
    bus.din_valid = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    check_val("idle_ignore_valid", int'(bus.busy), 0, 0);

    // Impulse at n=0, forward
    set_all(0); x_re[0] = 8192; model(1'b0);
    run_frame(1'b0, 100, 0, 1'b0, 0);
    cmp_model("impulse", 0);
    check_val("impulse_no_stall", out_span, N - 1, 0);
    check_val("impulse_compute", comp_cycles, 13, 1);

    // DC, forward
    set_all(8000); model(1'b0);
    run_frame(1'b0, 100, 0, 1'b0, 0);
    cmp_model("dc", 0);
    check_val("dc_compute", comp_cycles, 13, 1);

    // Shifted impulse, forward and inverse
    set_all(0); x_re[1] = 8192; model(1'b0);
    run_frame(1'b0, 100, 0, 1'b0, 0);
    cmp_model("shift_fwd", 1);
    model(1'b1);
    run_frame(1'b1, 100, 0, 1'b0, 0);
    cmp_model("shift_inv", 1);

    // Random frames: unstalled, then stressed handshakes with start noise
    for (int f = 0; f < 3; f++) begin
      bit inv;
      inv = $urandom_range(1) == 1;
      for (int n = 0; n < N; n++) begin
        x_re[n] = $urandom_range(16000) - 8000;
        x_im[n] = $urandom_range(16000) - 8000;
      end
      model(inv);
      run_frame(inv, 100, 0, 1'b0, 0);
      cmp_model("rand", 3);
      for (int k = 0; k < N; k++) begin ref_re[k] = got_re[k]; ref_im[k] = got_im[k]; end
      run_frame(inv, 50, (f == 0) ? 1 : 2, 1'b1, 0);
      cmp_model("stress", 3);
      for (int k = 0; k < N; k++) begin
        check_val($sformatf("stress_same_re[%0d]", k), got_re[k], ref_re[k], 0);
        check_val($sformatf("stress_same_im[%0d]", k), got_im[k], ref_im[k], 0);
      end
    end

    // Reset in the middle of COMPUTE, then a clean DC frame
    set_all(3000);
    run_frame(1'b0, 100, 0, 1'b0, 5);
    set_all(8000); model(1'b0);
    run_frame(1'b0, 100, 0, 1'b0, 0);
    cmp_model("dc_after_rst", 0);

    // N=16, DATA_WIDTH=12 build: DC of 1000
    @(posedge clk); #1;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    bus2.din_real = DW2'(1000); bus2.din_imag = '0; bus2.dout_ready = 1'b1;
    in2 = 0; out2 = 0; cyc2 = 0; acc2 = -1; fv2 = -1; fin2 = 1'b0;
    while (!fin2 && cyc2 < 3000) begin
      bus2.din_valid = in2 < N2;
      ov_pre2 = bus2.dout_valid;
      od2 = bus2.dout_real;
      if (bus2.din_valid && bus2.din_ready) begin
        in2++;
        if (in2 == N2) acc2 = cyc2 + 1;
      end
      @(posedge clk); #1;
      cyc2++;
      if (ov_pre2) begin
        check_val($sformatf("n16_re[%0d]", out2), od2, (out2 == 0) ? 1000 : 0, 0);
        out2++;
      end
      if (bus2.dout_valid && fv2 < 0) fv2 = cyc2;
      if (bus2.done) begin
        check_val("n16_bins", out2, N2, 0);
        fin2 = 1'b1;
      end
    end
    bus2.din_valid = 1'b0;
    if (!fin2) check_val("n16_timeout", 0, 1, 0);
    check_val("n16_compute", fv2 - acc2 - 1, 33, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
